// File: rtl/mac_tg_pkg.sv
// mac_tg_pkg
// Shared definitions for the MAC traffic generator/checker. It holds:
//   - the header field byte offsets and header size;
//   - the length-LFSR tap mask;
//   - the length-mode encoding;
//   - the expected-byte function, used by both the generator and the checker.
package mac_tg_pkg;

    localparam int HDR_BYTES  = 4;
    localparam int SEQ_HI_OFF = 0;
    localparam int SEQ_LO_OFF = 1;
    localparam int LEN_HI_OFF = 2;
    localparam int LEN_LO_OFF = 3;

    // Fibonacci taps 16,14,13,11 as a mask over bits [15:0] (tap n -> bit n-1).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        LEN_FIXED = 2'd0,
        LEN_INCR  = 2'd1,
        LEN_RAND  = 2'd2
    } len_mode_e;

    // Expected byte at packet offset k for the given sequence number and length.
    function automatic logic [7:0] exp_byte(input logic [15:0] seq,
                                            input logic [15:0] len,
                                            input logic [16:0] k);
        logic [7:0] b;
        if (k == 17'(SEQ_HI_OFF))      b = seq[15:8];
        else if (k == 17'(SEQ_LO_OFF)) b = seq[7:0];
        else if (k == 17'(LEN_HI_OFF)) b = len[15:8];
        else if (k == 17'(LEN_LO_OFF)) b = len[7:0];
        else                           b = seq[7:0] + k[7:0];
        return b;
    endfunction

endpackage

// File: rtl/mac_tg_checker.sv
// mac_tg_checker
// Checks the MAC RX stream against the generator's packet rules and keeps
// saturating status counters.
// Ports:
//   s_user_clk, r_global_rst                 clock, async active-low reset
//   rx_data_i/rx_vldb_i/rx_valid_i           RX beat (byte 0 in bits [7:0])
//   rx_last_i, rx_user_i                     end of packet, CRC-error flag
//   rx_pkt_cnt_o                             packets received
//   len_err_cnt_o, data_err_cnt_o            length / payload error packets
//   seq_err_cnt_o, crc_err_cnt_o             sequence gaps / CRC-flagged packets
module mac_tg_checker
    import mac_tg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                s_user_clk,
    input  logic                r_global_rst,
    input  logic [DATA_W-1:0]   rx_data_i,
    input  logic [DATA_W/8-1:0] rx_vldb_i,
    input  logic                rx_valid_i,
    input  logic                rx_last_i,
    input  logic                rx_user_i,
    output logic [CNT_W-1:0]    rx_pkt_cnt_o,
    output logic [CNT_W-1:0]    len_err_cnt_o,
    output logic [CNT_W-1:0]    data_err_cnt_o,
    output logic [CNT_W-1:0]    seq_err_cnt_o,
    output logic [CNT_W-1:0]    crc_err_cnt_o
);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic {RX_HDR, RX_BODY} rx_state_e;

    rx_state_e          state_q, state_d;
    logic [16:0]        rx_off_q;       // bytes received so far in this packet
    logic [15:0]        seq_q, len_q;   // captured header fields
    logic [15:0]        seq_exp_q;
    logic               hdr_used_q;     // header of this packet was complete
    logic               bad_q;          // sticky payload mismatch
    logic [CNT_W-1:0]   rx_cnt_q, len_err_q, data_err_q, seq_err_q, crc_err_q;

    logic               in_hdr;
    logic [15:0]        hdr_seq, hdr_len;
    logic               hdr_ok;
    logic [15:0]        beat_seq, beat_len;
    logic               beat_hdr_ok;
    logic [BYTES-1:0]   lane_bad;
    logic [16:0]        beat_cnt;
    logic [16:0]        rx_total;
    logic               len_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_hdr  = (state_q == RX_HDR);
    assign hdr_seq = {rx_data_i[SEQ_HI_OFF*8 +: 8], rx_data_i[SEQ_LO_OFF*8 +: 8]};
    assign hdr_len = {rx_data_i[LEN_HI_OFF*8 +: 8], rx_data_i[LEN_LO_OFF*8 +: 8]};
    // A first beat with fewer than HDR_BYTES valid bytes carries no usable header.
    assign hdr_ok  = &rx_vldb_i[HDR_BYTES-1:0];

    // On the first beat the header is taken straight from the bus so that
    // payload bytes sharing that beat (64-bit) are checked against it.
    assign beat_seq    = in_hdr ? hdr_seq : seq_q;
    assign beat_len    = in_hdr ? hdr_len : len_q;
    assign beat_hdr_ok = in_hdr ? hdr_ok  : hdr_used_q;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_rx_lane
            logic [16:0] lane_off;
            assign lane_off     = rx_off_q + 17'(gi);
            assign lane_bad[gi] = rx_vldb_i[gi] && beat_hdr_ok &&
                                  (lane_off >= 17'(HDR_BYTES)) &&
                                  (rx_data_i[gi*8 +: 8] != exp_byte(beat_seq, beat_len, lane_off));
        end
    endgenerate

    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            beat_cnt = beat_cnt + 17'(rx_vldb_i[i]);
        end
    end

    assign rx_total = rx_off_q + beat_cnt;
    assign len_bad  = (rx_total < 17'(HDR_BYTES)) || !beat_hdr_ok ||
                      (rx_total != {1'b0, beat_len});

    always_comb begin
        state_d = state_q;
        if (rx_valid_i) begin
            state_d = rx_last_i ? RX_HDR : RX_BODY;
        end
    end

    always_ff @(posedge s_user_clk or negedge r_global_rst) begin
        if (!r_global_rst) begin
            state_q    <= RX_HDR;
            rx_off_q   <= '0;
            seq_q      <= '0;
            len_q      <= '0;
            seq_exp_q  <= '0;
            hdr_used_q <= 1'b0;
            bad_q      <= 1'b0;
            rx_cnt_q   <= '0;
            len_err_q  <= '0;
            data_err_q <= '0;
            seq_err_q  <= '0;
            crc_err_q  <= '0;
        end else begin
            state_q <= state_d;
            if (rx_valid_i) begin
                if (in_hdr) begin
                    hdr_used_q <= hdr_ok;
                    if (hdr_ok) begin
                        seq_q     <= hdr_seq;
                        len_q     <= hdr_len;
                        // Resync on a gap so one lost packet costs one error.
                        seq_exp_q <= hdr_seq + 16'd1;
                        if (hdr_seq != seq_exp_q) begin
                            seq_err_q <= sat_inc(seq_err_q);
                        end
                    end
                end
                if (rx_last_i) begin
                    rx_off_q <= '0;
                    bad_q    <= 1'b0;
                    rx_cnt_q <= sat_inc(rx_cnt_q);
                    if (len_bad) begin
                        len_err_q <= sat_inc(len_err_q);
                    end
                    if (bad_q || (|lane_bad)) begin
                        data_err_q <= sat_inc(data_err_q);
                    end
                    if (rx_user_i) begin
                        crc_err_q <= sat_inc(crc_err_q);
                    end
                end else begin
                    rx_off_q <= rx_total;
                    bad_q    <= bad_q | (|lane_bad);
                end
            end
        end
    end

    assign rx_pkt_cnt_o   = rx_cnt_q;
    assign len_err_cnt_o  = len_err_q;
    assign data_err_cnt_o = data_err_q;
    assign seq_err_cnt_o  = seq_err_q;
    assign crc_err_cnt_o  = crc_err_q;

endmodule

// File: rtl/mac_traffic_gen_chk.sv
// mac_traffic_gen_chk
// Self-describing packet generator for the MAC TX stream plus an RX checker,
// giving loopback pass/fail and error counters.
// Ports:
//   s_user_clk, r_global_rst       clock, async active-low reset
//   enable_i, num_pkts_i           run control (num_pkts_i = 0 -> continuous)
//   err_inj_i                      mark the next started packet bad (tx_user)
//   tx_*                           TX stream to the MAC
//   rx_*                           RX stream from the MAC (rx_ready_o tied high)
//   tx_pkt_cnt_o, rx_pkt_cnt_o     packet counters
//   len/data/seq/crc_err_cnt_o     error counters
//   done_o, pass_o                 run complete / complete with no errors
module mac_traffic_gen_chk
    import mac_tg_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          MIN_LEN    = 60,
    parameter int          MAX_LEN    = 1514,
    parameter int          LEN_MODE   = 1,
    parameter int          IPG_CYCLES = 2,
    parameter int          CNT_W      = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                s_user_clk,
    input  logic                r_global_rst,
    input  logic                enable_i,
    input  logic [CNT_W-1:0]    num_pkts_i,
    input  logic                err_inj_i,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic [DATA_W/8-1:0] tx_vldb_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                tx_last_o,
    output logic                tx_user_o,
    input  logic [DATA_W-1:0]   rx_data_i,
    input  logic [DATA_W/8-1:0] rx_vldb_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    input  logic                rx_last_i,
    input  logic                rx_user_i,
    output logic [CNT_W-1:0]    tx_pkt_cnt_o,
    output logic [CNT_W-1:0]    rx_pkt_cnt_o,
    output logic [CNT_W-1:0]    len_err_cnt_o,
    output logic [CNT_W-1:0]    data_err_cnt_o,
    output logic [CNT_W-1:0]    seq_err_cnt_o,
    output logic [CNT_W-1:0]    crc_err_cnt_o,
    output logic                done_o,
    output logic                pass_o
);
    localparam int          BYTES    = DATA_W / 8;
    localparam logic [15:0] GAP_LOAD = (IPG_CYCLES > 0) ? 16'(IPG_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_e;

    tx_state_e          state_q, state_d;
    logic [15:0]        gap_q, gap_d;
    logic [16:0]        byte_off_q;     // offset of the current beat's byte 0
    logic [15:0]        pkt_len_q;
    logic [15:0]        seq_q;
    logic [CNT_W-1:0]   tx_cnt_q;
    logic               inj_pend_q;     // injection requested, not yet consumed
    logic               inj_pkt_q;      // current packet carries the injection
    logic [15:0]        incr_len_q;
    logic [15:0]        lfsr_q;
    logic [CNT_W-1:0]   num_q;
    logic               done_q;

    logic               sending, beat_acc, last_beat;
    logic [16:0]        beat_end;
    logic [CNT_W-1:0]   tx_cnt_inc;
    logic               start_ok_now, start_ok_inc;
    logic               start_pkt, pkt_done;
    logic [16:0]        rand_sum;
    logic [15:0]        len_next;

    logic [CNT_W-1:0]   rx_cnt, len_err, data_err, seq_err, crc_err;

    // ---------------- length unit ----------------
    assign rand_sum = 17'(MIN_LEN) + {6'd0, lfsr_q[10:0]};

    always_comb begin
        len_next = 16'(MIN_LEN);
        if (LEN_MODE == int'(LEN_INCR)) begin
            len_next = incr_len_q;
        end else if (LEN_MODE == int'(LEN_RAND)) begin
            len_next = (rand_sum > 17'(MAX_LEN)) ? 16'(MIN_LEN) : rand_sum[15:0];
        end
    end

    // ---------------- TX FSM ----------------
    assign sending    = (state_q == TX_SEND);
    assign beat_acc   = sending & tx_ready_i;
    assign beat_end   = byte_off_q + 17'(BYTES);
    assign last_beat  = (beat_end >= {1'b0, pkt_len_q});
    assign tx_cnt_inc = (&tx_cnt_q) ? tx_cnt_q : tx_cnt_q + CNT_W'(1);

    assign start_ok_now = enable_i && ((num_pkts_i == '0) || (tx_cnt_q < num_pkts_i));
    // With no gap the restart decision is made on the same cycle the count bumps.
    assign start_ok_inc = enable_i && ((num_pkts_i == '0) || (tx_cnt_inc < num_pkts_i));

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        start_pkt = 1'b0;
        pkt_done  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_ok_now) begin
                    state_d   = TX_SEND;
                    start_pkt = 1'b1;
                end
            end
            TX_SEND: begin
                if (beat_acc && last_beat) begin
                    pkt_done = 1'b1;
                    if (IPG_CYCLES > 0) begin
                        state_d = TX_GAP;
                        gap_d   = GAP_LOAD;
                    end else if (start_ok_inc) begin
                        start_pkt = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            TX_GAP: begin
                if (gap_q == 16'd0) begin
                    if (start_ok_now) begin
                        state_d   = TX_SEND;
                        start_pkt = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge s_user_clk or negedge r_global_rst) begin
        if (!r_global_rst) begin
            state_q    <= TX_IDLE;
            gap_q      <= '0;
            byte_off_q <= '0;
            pkt_len_q  <= '0;
            seq_q      <= '0;
            tx_cnt_q   <= '0;
            inj_pend_q <= 1'b0;
            inj_pkt_q  <= 1'b0;
            incr_len_q <= 16'(MIN_LEN);
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            // A request arriving on the start cycle is folded into that packet.
            inj_pend_q <= (inj_pend_q | err_inj_i) & ~start_pkt;
            if (start_pkt) begin
                byte_off_q <= '0;
                pkt_len_q  <= len_next;
                inj_pkt_q  <= inj_pend_q | err_inj_i;
                incr_len_q <= (incr_len_q >= 16'(MAX_LEN)) ? 16'(MIN_LEN) : incr_len_q + 16'd1;
                lfsr_q     <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            end else if (beat_acc) begin
                byte_off_q <= beat_end;
            end
            if (pkt_done) begin
                tx_cnt_q <= tx_cnt_inc;
                seq_q    <= seq_q + 16'd1;
            end
        end
    end

    // Beat contents are pure functions of registered state, so they hold
    // steady while the MAC stalls.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_tx_lane
            logic [16:0] lane_off;
            assign lane_off                = byte_off_q + 17'(gi);
            assign tx_vldb_o[gi]           = sending && (lane_off < {1'b0, pkt_len_q});
            assign tx_data_o[gi*8 +: 8]    = tx_vldb_o[gi] ? exp_byte(seq_q, pkt_len_q, lane_off) : 8'h00;
        end
    endgenerate

    assign tx_valid_o = sending;
    assign tx_last_o  = sending & last_beat;
    assign tx_user_o  = sending & last_beat & inj_pkt_q;

    // ---------------- RX checker ----------------
    mac_tg_checker #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_checker (
        .s_user_clk     (s_user_clk),
        .r_global_rst   (r_global_rst),
        .rx_data_i      (rx_data_i),
        .rx_vldb_i      (rx_vldb_i),
        .rx_valid_i     (rx_valid_i),
        .rx_last_i      (rx_last_i),
        .rx_user_i      (rx_user_i),
        .rx_pkt_cnt_o   (rx_cnt),
        .len_err_cnt_o  (len_err),
        .data_err_cnt_o (data_err),
        .seq_err_cnt_o  (seq_err),
        .crc_err_cnt_o  (crc_err)
    );

    assign rx_ready_o = 1'b1;

    // ---------------- status ----------------
    // done is sticky; a change of the requested count re-arms it.
    always_ff @(posedge s_user_clk or negedge r_global_rst) begin
        if (!r_global_rst) begin
            num_q  <= '0;
            done_q <= 1'b0;
        end else begin
            num_q <= num_pkts_i;
            if (num_pkts_i != num_q) begin
                done_q <= 1'b0;
            end else if ((num_pkts_i != '0) && (tx_cnt_q == num_pkts_i) && (rx_cnt == num_pkts_i)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign tx_pkt_cnt_o   = tx_cnt_q;
    assign rx_pkt_cnt_o   = rx_cnt;
    assign len_err_cnt_o  = len_err;
    assign data_err_cnt_o = data_err;
    assign seq_err_cnt_o  = seq_err;
    assign crc_err_cnt_o  = crc_err;
    assign done_o         = done_q;
    assign pass_o         = done_q && (len_err == '0) && (data_err == '0) &&
                            (seq_err == '0) && (crc_err == '0);

endmodule

// File: tb/tb_mac_traffic_gen_chk.sv
`timescale 1ns/1ps
module tb_mac_traffic_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // 32-bit instance (incrementing lengths 60..)
    logic        enable, err_inj;
    logic [31:0] num_pkts;
    logic [31:0] tx_data;
    logic [3:0]  tx_vldb;
    logic        tx_valid, tx_ready, tx_last, tx_user;
    logic [31:0] rx_data;
    logic [3:0]  rx_vldb;
    logic        rx_valid, rx_ready, rx_last, rx_user;
    logic [31:0] tx_cnt, rx_cnt, len_err, data_err, seq_err, crc_err;
    logic        done, pass;

    // 64-bit instance (fixed length 61), plain loopback
    logic        enable64, err_inj64, tx_ready64;
    logic [31:0] num64;
    logic [63:0] tx_data64;
    logic [7:0]  tx_vldb64;
    logic        tx_valid64, tx_last64, tx_user64, rx_ready64;
    logic [31:0] tx_cnt64, rx_cnt64, len_err64, data_err64, seq_err64, crc_err64;
    logic        done64, pass64;

    // loop-path fault controls
    logic        drop_en, flip_en, trunc_en, stall_en;
    logic [15:0] lp_pkt, lp_beat;

    mac_traffic_gen_chk #(.DATA_W(32), .MIN_LEN(60), .MAX_LEN(1514), .LEN_MODE(1)) u_dut (
        .s_user_clk(clk), .r_global_rst(rst_n), .enable_i(enable), .num_pkts_i(num_pkts),
        .err_inj_i(err_inj), .tx_data_o(tx_data), .tx_vldb_o(tx_vldb), .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready), .tx_last_o(tx_last), .tx_user_o(tx_user),
        .rx_data_i(rx_data), .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .rx_last_i(rx_last), .rx_user_i(rx_user), .tx_pkt_cnt_o(tx_cnt), .rx_pkt_cnt_o(rx_cnt),
        .len_err_cnt_o(len_err), .data_err_cnt_o(data_err), .seq_err_cnt_o(seq_err),
        .crc_err_cnt_o(crc_err), .done_o(done), .pass_o(pass)
    );

    mac_traffic_gen_chk #(.DATA_W(64), .MIN_LEN(61), .MAX_LEN(1514), .LEN_MODE(0)) u_dut64 (
        .s_user_clk(clk), .r_global_rst(rst_n), .enable_i(enable64), .num_pkts_i(num64),
        .err_inj_i(err_inj64), .tx_data_o(tx_data64), .tx_vldb_o(tx_vldb64), .tx_valid_o(tx_valid64),
        .tx_ready_i(tx_ready64), .tx_last_o(tx_last64), .tx_user_o(tx_user64),
        .rx_data_i(tx_data64), .rx_vldb_i(tx_vldb64), .rx_valid_i(tx_valid64 & tx_ready64),
        .rx_ready_o(rx_ready64), .rx_last_i(tx_last64), .rx_user_i(tx_user64),
        .tx_pkt_cnt_o(tx_cnt64), .rx_pkt_cnt_o(rx_cnt64), .len_err_cnt_o(len_err64),
        .data_err_cnt_o(data_err64), .seq_err_cnt_o(seq_err64), .crc_err_cnt_o(crc_err64),
        .done_o(done64), .pass_o(pass64)
    );

    // Loop path position, counted on accepted beats.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_pkt  <= '0;
            lp_beat <= '0;
        end else if (tx_valid && tx_ready) begin
            if (tx_last) begin
                lp_pkt  <= lp_pkt + 16'd1;
                lp_beat <= '0;
            end else begin
                lp_beat <= lp_beat + 16'd1;
            end
        end
    end

    // Loopback with optional drop (seq 5), byte-10 flip (pkt 3), 2-byte truncation (pkt 8).
    assign rx_valid = tx_valid & tx_ready & ~(drop_en & (lp_pkt == 16'd5));
    assign rx_data  = tx_data ^ ((flip_en && lp_pkt == 16'd3 && lp_beat == 16'd2) ? 32'h00FF_0000 : 32'h0);
    assign rx_vldb  = (trunc_en && lp_pkt == 16'd8 && tx_last) ? (tx_vldb >> 2) : tx_vldb;
    assign rx_last  = tx_last;
    assign rx_user  = tx_user;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Independent model of the TX byte for packet idx (seq = idx, L = 60 + idx).
    function automatic logic [7:0] tx_byte(input int idx, input int k);
        logic [15:0] s;
        logic [15:0] l;
        logic [7:0]  kb;
        s  = idx[15:0];
        l  = 16'(60 + idx);
        kb = k[7:0];
        if (k == 0)      return s[15:8];
        else if (k == 1) return s[7:0];
        else if (k == 2) return l[15:8];
        else if (k == 3) return l[7:0];
        else             return s[7:0] + kb;
    endfunction

    // TX monitor (32-bit instance), sampled on the falling edge.
    int          mon_idx, mon_off, mon_beats, byte_err, len_bad, hold_err, stall_seen;
    int          user_cnt, user_pkt;
    int          beats_arr [128];
    logic [3:0]  vldb_arr  [128];
    logic        prev_stall;
    logic [31:0] s_data;
    logic [3:0]  s_vldb;
    logic        s_last, s_user;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_idx = 0; mon_off = 0; mon_beats = 0; byte_err = 0; len_bad = 0;
                hold_err = 0; stall_seen = 0; user_cnt = 0; user_pkt = -1; prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!tx_valid || tx_data !== s_data || tx_vldb !== s_vldb ||
                                   tx_last !== s_last || tx_user !== s_user)) begin
                    hold_err++;
                end
                prev_stall = tx_valid && !tx_ready;
                s_data = tx_data; s_vldb = tx_vldb; s_last = tx_last; s_user = tx_user;
                if (prev_stall) stall_seen++;
                if (tx_valid && tx_ready) begin
                    int nb;
                    nb = 0;
                    for (int b = 0; b < 4; b++) begin
                        if (tx_vldb[b]) begin
                            if (tx_data[b*8 +: 8] !== tx_byte(mon_idx, mon_off + b)) byte_err++;
                            nb++;
                        end
                    end
                    mon_off += nb;
                    mon_beats++;
                    if (tx_last) begin
                        if (mon_off != 60 + mon_idx) len_bad++;
                        if (mon_idx < 128) begin
                            beats_arr[mon_idx] = mon_beats;
                            vldb_arr[mon_idx]  = tx_vldb;
                        end
                        if (tx_user) begin
                            user_cnt++;
                            user_pkt = mon_idx;
                        end
                        mon_idx++;
                        mon_off   = 0;
                        mon_beats = 0;
                    end
                end
            end
        end
    end

    // 64-bit monitor: first packet shape.
    int          m64_idx, m64_beats, m64_b0;
    logic [7:0]  m64_v0;
    logic [63:0] m64_first;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m64_idx = 0; m64_beats = 0; m64_b0 = 0; m64_v0 = '0; m64_first = '0;
            end else if (tx_valid64 && tx_ready64) begin
                if (m64_idx == 0 && m64_beats == 0) m64_first = tx_data64;
                m64_beats++;
                if (tx_last64) begin
                    if (m64_idx == 0) begin
                        m64_b0 = m64_beats;
                        m64_v0 = tx_vldb64;
                    end
                    m64_idx++;
                    m64_beats = 0;
                end
            end
        end
    end

    // TX ready driver: always ready, or random ~50% while stalling.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_run(input int n, input int n64);
        enable = 1'b0; enable64 = 1'b0; err_inj = 1'b0;
        rst_n = 1'b0;
        num_pkts = n; num64 = n64;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;
        enable64 = (n64 != 0);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c;
        c = 0;
        while (tx_cnt < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (tx_cnt < n) check_eq("wait_tx_timeout", tx_cnt, n);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0; enable = 1'b0; enable64 = 1'b0; err_inj = 1'b0; err_inj64 = 1'b0;
        tx_ready64 = 1'b1; num_pkts = '0; num64 = '0;
        drop_en = 1'b0; flip_en = 1'b0; trunc_en = 1'b0; stall_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data",  tx_data, 0);
        check_eq("rst_tx_cnt",   tx_cnt, 0);
        check_eq("rst_rx_ready", rx_ready, 1);
        check_eq("rst_done",     done, 0);

        // Run A: 100 packets, clean loopback; 64-bit instance sends 3 of L=61.
        start_run(100, 3);
        wait_tx(100, 20000);
        check_eq("A_tx_cnt",    tx_cnt, 100);
        check_eq("A_rx_cnt",    rx_cnt, 100);
        check_eq("A_errs",      len_err + data_err + seq_err + crc_err, 0);
        check_eq("A_done",      done, 1);
        check_eq("A_pass",      pass, 1);
        check_eq("A_tx_bytes",  byte_err, 0);
        check_eq("A_tx_lens",   len_bad, 0);
        check_eq("A_mon_pkts",  mon_idx, 100);
        check_eq("A_L60_beats", beats_arr[0], 15);
        check_eq("A_L61_beats", beats_arr[1], 16);
        check_eq("A_L61_vldb",  vldb_arr[1], 4'h1);
        check_eq("A_L64_beats", beats_arr[4], 16);
        check_eq("A_L64_vldb",  vldb_arr[4], 4'hF);
        check_eq("A64_beats",   m64_b0, 8);
        check_eq("A64_vldb",    m64_v0, 8'h1F);
        check_eq("A64_hdr",     m64_first, 64'h0706_0504_3D00_0000);
        check_eq("A64_rx_cnt",  rx_cnt64, 3);
        check_eq("A64_pass",    pass64, 1);

        // Run B: random stalls.
        stall_en = 1'b1;
        start_run(30, 0);
        wait_tx(30, 20000);
        stall_en = 1'b0;
        check_eq("B_rx_cnt",     rx_cnt, 30);
        check_eq("B_tx_eq_rx",   tx_cnt, rx_cnt);
        check_eq("B_errs",       len_err + data_err + seq_err + crc_err, 0);
        check_eq("B_hold",       hold_err, 0);
        check_eq("B_stalled",    stall_seen > 0, 1);
        check_eq("B_tx_bytes",   byte_err, 0);
        check_eq("B_pass",       pass, 1);

        // Run C: drop packet seq 5.
        drop_en = 1'b1;
        start_run(100, 0);
        wait_tx(100, 20000);
        check_eq("C_seq_err",  seq_err, 1);
        check_eq("C_rx_cnt",   rx_cnt, 99);
        check_eq("C_data_err", data_err, 0);
        check_eq("C_len_err",  len_err, 0);
        check_eq("C_done",     done, 0);
        drop_en = 1'b0;

        // Run D: error injection while packet 2 is in flight -> packet 3 flagged.
        start_run(10, 0);
        c = 0;
        while (!(tx_cnt == 2 && tx_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("D_reach_pkt2", tx_cnt, 2);
        err_inj = 1'b1;
        @(posedge clk);
        #1 err_inj = 1'b0;
        wait_tx(10, 5000);
        check_eq("D_crc_err",  crc_err, 1);
        check_eq("D_user_cnt", user_cnt, 1);
        check_eq("D_user_pkt", user_pkt, 3);
        check_eq("D_data_err", data_err, 0);
        check_eq("D_rx_cnt",   rx_cnt, 10);
        check_eq("D_done",     done, 1);
        check_eq("D_pass",     pass, 0);

        // Run E: flip byte 10 of packet 3, truncate packet 8 by 2 bytes.
        flip_en = 1'b1; trunc_en = 1'b1;
        start_run(20, 0);
        wait_tx(20, 8000);
        check_eq("E_data_err", data_err, 1);
        check_eq("E_len_err",  len_err, 1);
        check_eq("E_seq_err",  seq_err, 0);
        check_eq("E_crc_err",  crc_err, 0);
        check_eq("E_rx_cnt",   rx_cnt, 20);
        check_eq("E_pass",     pass, 0);
        flip_en = 1'b0; trunc_en = 1'b0;

        // Run F: asynchronous reset in the middle of a packet.
        start_run(0, 0);
        c = 0;
        while (!(tx_cnt >= 3 && tx_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("F_pre_valid", tx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("F_tx_valid", tx_valid, 0);
        check_eq("F_tx_last",  tx_last, 0);
        check_eq("F_tx_cnt",   tx_cnt, 0);
        check_eq("F_rx_cnt",   rx_cnt, 0);
        check_eq("F_errs",     len_err + data_err + seq_err + crc_err, 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_traffic_gen_chk.md
Name: mac_traffic_gen_chk

Overview:
- Synthesizable packet generator and checker for the 10G MAC user-side stream interfaces.
- Drives the MAC TX stream with self-describing packets and checks the MAC RX stream against the same rule set.
- Gives on-chip and in-sim loopback pass/fail with error counters.
- Generalises the loopback bench traffic: parametrised width and length mode, plus error injection, sequence-loss detection and CRC-flag accounting.

Parameters:
- DATA_W, 32, stream data width; legal values 32 or 64.
- MIN_LEN, 60, minimum packet length in bytes; must be ≥4.
- MAX_LEN, 1514, maximum packet length in bytes; must be ≥MIN_LEN and ≤65535.
- LEN_MODE, 1, length sequence: 0 = fixed MIN_LEN, 1 = incrementing with wrap, 2 = pseudo-random.
- IPG_CYCLES, 2, idle cycles inserted between TX packets.
- CNT_W, 32, width of all status counters.
- LFSR_SEED, 16'hACE1, reset seed of the length LFSR; must be non-zero.

Ports:
- s_user_clk  in  1  user clock for both streams.
- r_global_rst  in  1  asynchronous active-low reset.
- enable_i  in  1  run generator while high.
- num_pkts_i  in  CNT_W  packets to send; 0 = continuous.
- err_inj_i  in  1  pulse: the next started packet carries tx_user=1 on its eop beat.
- tx_data_o  out  DATA_W  TX data; byte 0 of the beat is in bits [7:0].
- tx_vldb_o  out  DATA_W/8  byte-valid mask, contiguous from LSB.
- tx_valid_o  out  1  TX beat valid.
- tx_ready_i  in  1  MAC accepts the beat.
- tx_last_o  out  1  end of packet.
- tx_user_o  out  1  abort/bad-frame marker, meaningful on the last beat only.
- rx_data_i  in  DATA_W  RX data.
- rx_vldb_i  in  DATA_W/8  RX byte-valid mask.
- rx_valid_i  in  1  RX beat valid.
- rx_ready_o  out  1  RX ready; tied to 1.
- rx_last_i  in  1  RX end of packet.
- rx_user_i  in  1  CRC-error flag, meaningful on the last beat only.
- tx_pkt_cnt_o  out  CNT_W  packets fully sent.
- rx_pkt_cnt_o  out  CNT_W  packets received.
- len_err_cnt_o  out  CNT_W  packets whose byte count differs from the header length, or shorter than 4 bytes.
- data_err_cnt_o  out  CNT_W  packets with at least one payload byte mismatch.
- seq_err_cnt_o  out  CNT_W  sequence-number discontinuities.
- crc_err_cnt_o  out  CNT_W  packets with rx_user=1 on the last beat.
- done_o  out  1  tx count reached num_pkts_i and rx_pkt_cnt equals it.
- pass_o  out  1  done_o and all four error counters zero.

Behaviour:
- Reset (r_global_rst=0, asynchronous):
  - All outputs 0 except rx_ready_o=1.
  - Length LFSR = LFSR_SEED; TX and RX sequence counters = 0.
  - Reset mid-packet abandons the packet with no eop.
- Packet format, seq = 16-bit TX sequence number and L = length:
  - byte0 = seq[15:8], byte1 = seq[7:0], byte2 = L[15:8], byte3 = L[7:0].
  - byte k (k ≥ 4) = (seq[7:0] + k[7:0]) mod 256.
- Length sequence:
  - Mode 0: L = MIN_LEN.
  - Mode 1: L starts at MIN_LEN, +1 per packet, MAX_LEN wraps to MIN_LEN.
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, stepped once per packet. L = MIN_LEN + lfsr[10:0]; any L > MAX_LEN is replaced by MIN_LEN.
- Beat packing:
  - Beat count = ceil(L/(DATA_W/8)).
  - tx_vldb_o is all ones except on the last beat, which has (L mod bytes) LSBs set, or all ones when the remainder is 0.
- TX FSM: IDLE → SEND → GAP → (SEND | IDLE).
  - IDLE→SEND when enable_i=1 and (num_pkts_i=0 or tx_pkt_cnt<num_pkts_i).
  - In SEND, data/vldb/last/user are held stable while valid=1 and ready=0. A beat advances only on valid&ready.
  - Last beat accepted → tx_pkt_cnt +1 and seq +1 on the next cycle, then GAP for IPG_CYCLES cycles.
  - IPG_CYCLES=0 goes straight back to SEND.
  - enable_i falling mid-packet: the packet completes first, then IDLE.
  - err_inj_i is latched; the latch is consumed at the next packet start and that packet's last beat has tx_user=1. Injections while one is already pending merge into one.
- RX checker FSM: HDR → BODY.
  - A beat counts only when rx_valid_i=1.
  - First beat: capture seq/L. If seq ≠ expected, seq_err +1 and resync expected := rx_seq+1; otherwise expected +1.
  - Byte compare covers only bytes set in rx_vldb_i.
  - On the last beat:
    - rx_pkt_cnt +1.
    - len_err +1 if received bytes ≠ L.
    - data_err +1 if any payload mismatch flag is set (sticky per packet).
    - crc_err +1 if rx_user_i=1.
  - All counter updates are visible 1 cycle after the last beat.
  - A packet shorter than 4 bytes counts as a len_err only; its header is not used.
- Counters saturate at all ones.
- done_o requires num_pkts_i ≠ 0. It is registered and stays high until reset or a num_pkts_i change.

Decomposition:
- Shared package mac_tg_pkg holds:
  - the header field offsets and HDR_BYTES=4;
  - the LFSR tap constant;
  - the length-mode enum (LEN_FIXED, LEN_INCR, LEN_RAND);
  - the function computing the expected byte at offset k.
- One sub-module, mac_tg_checker, contains the RX FSM and error counters. Generator, length unit and status logic stay in the top.

Test Plan:
- DATA_W=32, LEN_MODE=1, num_pkts=100, tx_ready=1, TX looped to RX → lengths 60..159, rx_pkt_cnt=100, all error counts 0, pass_o=1.
- DATA_W=64, L=61 → last beat vldb=8'h1F, 8 beats. DATA_W=32, L=64 → last beat vldb=4'hF, 16 beats.
- Random tx_ready stall ~50% → TX data unchanged during stalls, zero errors, tx_pkt_cnt=rx_pkt_cnt.
- Drop packet seq=5 in the loop path → seq_err=1, rx_pkt_cnt=99, data_err=0, done_o=0.
- err_inj_i pulse before packet 3, loop path maps tx_user to rx_user → crc_err=1, only packet 3 flagged.
- Flip byte 10 of one packet → data_err=1. Truncate one packet by 2 bytes → len_err=1. Reset asserted mid-packet → all counters 0, tx_valid_o=0 immediately.
